bus_xfer_ctrl: RTL
==================

Name: bus_xfer_ctrl

Overview:
- Bus-side initiator for the 16-bit shared-bus register file.
- Sequences the LOAD/ENABLE strobes of NREG bus registers to move one word from a source register to a destination register, or from an external word onto the bus into a destination register.
- Guarantees at most one bus driver at any time.
- Sits between the datapath control unit and the bank of bus registers.

Parameters:
- NREG, 4, number of bus registers controlled (2..16)
- WIDTH, 16, bus data width
- SELW, 2, width of register select fields; must satisfy 2**SELW >= NREG

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a transfer; sampled only in IDLE
- src  input  SELW  source register index
- dst  input  SELW  destination register index
- ext_sel  input  1  1 = source is ext_data, not a register
- ext_data  input  WIDTH  external word to place on bus
- bus  output  WIDTH  tristate drive of ext_data; z unless ext_drive
- ENABLE  output  NREG  one-hot output-enable strobe to registers
- LOAD  output  NREG  one-hot load strobe to registers
- ext_drive  output  1  controller is driving bus
- busy  output  1  high from cycle after accepted start until return to IDLE
- done  output  1  one-cycle pulse on successful completion
- err  output  1  one-cycle pulse on rejected request

Behaviour:
- Reset (synchronous, active-high): state=IDLE; ENABLE=0, LOAD=0, ext_drive=0, busy=0, done=0, err=0; bus=z. Reset mid-transfer aborts; all strobes low on the next edge; no partial LOAD is ever left asserted.
- States: IDLE, DRIVE, LATCH, HOLD, FIN.
- IDLE: start=1 latches src/dst/ext_sel/ext_data into internal holds, then goes to DRIVE. Reject and stay in IDLE with err pulse if:
  - dst>=NREG;
  - ext_sel=0 and src>=NREG; or
  - ext_sel=0 and src==dst.
- DRIVE, 1 cycle: assert source driver (ENABLE[src] or ext_drive). LOAD=0. Bus settle cycle.
- LATCH, 1 cycle: source still driving; LOAD[dst]=1.
- HOLD, 1 cycle: LOAD=0; source still driving (hold time).
- FIN, 1 cycle: all strobes 0; done=1; back to IDLE.
- Latency: start accepted at edge N, done high in cycle N+4; next start accepted at the edge ending FIN+1 (IDLE). Back-to-back throughput is 1 transfer per 5 cycles.
- start while busy is ignored (not queued). Input changes while busy have no effect (latched copies used).
- Invariants checked by the bench:
  - popcount(ENABLE)+ext_drive <= 1 every cycle;
  - popcount(LOAD) <= 1;
  - LOAD[i] only while a driver is active and never co-asserted with ENABLE[i].
- All outputs are registered; no combinational path from inputs to strobes.
- ext_data is latched at accept; bus carries latched value while ext_drive=1, else all-z.

Optional Feature:
- Macro XFER_COUNT_EN.
- Defined: adds output xfer_count [7:0]. Reset to 0. Increments on each done pulse; wraps 255->0. err does not count.
- Undefined: port xfer_count absent; no counter logic.

Test Plan:
- Reg move: start, src=1, dst=2, ext_sel=0 -> ENABLE=0010 cycles N+1..N+3; LOAD=0100 only at N+2; done at N+4; busy N+1..N+4.
- External load: ext_sel=1, ext_data=16'hA5C3, dst=3 -> bus=A5C3 and ext_drive=1 for 3 cycles; LOAD=1000 in middle cycle; ENABLE=0000 throughout; bus=z afterwards.
- Illegal: src=dst=2, ext_sel=0 -> err pulse next cycle; busy, LOAD and ENABLE stay 0; no done. Same for dst=3 with NREG=3.
- Busy/ignore: start held high for 10 cycles with src=0, dst=1, changing src mid-way to 3 -> exactly 2 transfers, both use src=0 (latched per accept), done pulses 5 cycles apart.
- Reset mid-op: assert rst during LATCH -> next edge LOAD=0, ENABLE=0, busy=0, done=0; fresh transfer afterwards completes normally.
- XFER_COUNT_EN: 257 legal transfers plus 3 errored -> xfer_count=1.

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bus_xfer_ctrl
// Function : Shared-bus transfer initiator. Sequences ENABLE/LOAD strobes to
//            move one word register->register or external word->register.
//            Optional macro XFER_COUNT_EN adds an 8-bit completed-transfer count.
// Revision : 1.0
// ============================================================================
module bus_xfer_ctrl #(
  parameter int NREG  = 4,
  parameter int WIDTH = 16,
  parameter int SELW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SELW-1:0]  src,
  input  logic [SELW-1:0]  dst,
  input  logic             ext_sel,
  input  logic [WIDTH-1:0] ext_data,
  output logic [WIDTH-1:0] bus,
  output logic [NREG-1:0]  ENABLE,
  output logic [NREG-1:0]  LOAD,
  output logic             ext_drive,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef XFER_COUNT_EN
  ,
  output logic [7:0]       xfer_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_LATCH = 3'd2,
    S_HOLD  = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [SELW-1:0]  src_q, src_d, dst_q, dst_d;
  logic             ext_q, ext_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [NREG-1:0]  enable_q, enable_d, load_q, load_d;
  logic             drive_q, drive_d, busy_q, busy_d;
  logic             done_q, done_d, err_q, err_d;
  logic             reject;

  function automatic logic [NREG-1:0] onehot(input logic [SELW-1:0] idx);
    return ONE << idx;
  endfunction

  assign reject = (int'(dst) >= NREG) ||
                  (!ext_sel && ((int'(src) >= NREG) || (src == dst)));

  // Strobes are computed for the state being entered, then registered, so
  // every output is a flop and nothing combinational reaches the bus strobes.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    ext_d    = ext_q;
    data_d   = data_q;
    enable_d = '0;
    load_d   = '0;
    drive_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            src_d   = src;
            dst_d   = dst;
            ext_d   = ext_sel;
            data_d  = ext_data;
            state_d = S_DRIVE;
            busy_d  = 1'b1;
            if (ext_sel) drive_d = 1'b1;
            else         enable_d = onehot(src);
          end
        end
      end
      S_DRIVE: begin
        state_d  = S_LATCH;
        busy_d   = 1'b1;
        drive_d  = ext_q;
        enable_d = ext_q ? '0 : onehot(src_q);
        load_d   = onehot(dst_q);
      end
      S_LATCH: begin
        state_d  = S_HOLD;
        busy_d   = 1'b1;
        drive_d  = ext_q;
        enable_d = ext_q ? '0 : onehot(src_q);
      end
      S_HOLD: begin
        state_d = S_FIN;
        busy_d  = 1'b1;
        done_d  = 1'b1;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      ext_q    <= 1'b0;
      data_q   <= '0;
      enable_q <= '0;
      load_q   <= '0;
      drive_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      ext_q    <= ext_d;
      data_q   <= data_d;
      enable_q <= enable_d;
      load_q   <= load_d;
      drive_q  <= drive_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus       = drive_q ? data_q : {WIDTH{1'bz}};
  assign ENABLE    = enable_q;
  assign LOAD      = load_q;
  assign ext_drive = drive_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef XFER_COUNT_EN
  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (rst)         count_q <= 8'd0;
    else if (done_d) count_q <= count_q + 8'd1;
  end

  assign xfer_count = count_q;
`endif

endmodule
`default_nettype wire
